// File: rtl/ram_dp.sv
// ram_dp: true dual-port byte-strobed RAM with synchronous read and write-collision flag
// Ports A and B are identical: en/we request, addr, wr_data, wr_strobe (byte enables),
// rd_data/rd_valid returned READ_LATENCY cycles after a read is sampled.
// collision pulses the cycle after both ports write overlapping lanes of one address.
`ifndef DEFAULT_RAM_ADDR_WIDTH
`define DEFAULT_RAM_ADDR_WIDTH 10
`endif
module ram_dp #(
  parameter int ADDR_WIDTH   = `DEFAULT_RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_en,
  input  logic                    a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wr_data,
  input  logic [DATA_WIDTH/8-1:0] a_wr_strobe,
  output logic [DATA_WIDTH-1:0]   a_rd_data,
  output logic                    a_rd_valid,
  input  logic                    b_en,
  input  logic                    b_we,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wr_data,
  input  logic [DATA_WIDTH/8-1:0] b_wr_strobe,
  output logic [DATA_WIDTH-1:0]   b_rd_data,
  output logic                    b_rd_valid,
  output logic                    collision
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_dw
    $error("ram_dp: DATA_WIDTH must be a multiple of 8 in 8..64");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("ram_dp: READ_LATENCY must be 1 or 2");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [1:0] rd, wr, v1, v2;
  logic [1:0][DATA_WIDTH-1:0] rd_word, d1, d2;
  logic same_addr;
  assign rd = {b_en & ~b_we, a_en & ~a_we};
  assign wr = {b_en & b_we, a_en & a_we};
  assign same_addr = a_addr == b_addr;
  // Write-first mode forwards the other port's strobed bytes into this port's read word
  always_comb begin
    rd_word[0] = mem[a_addr];
    rd_word[1] = mem[b_addr];
    for (int k = 0; k < NB; k++) begin
      if (RDW_MODE == 1 && wr[1] && same_addr && b_wr_strobe[k]) rd_word[0][k*8 +: 8] = b_wr_data[k*8 +: 8];
      if (RDW_MODE == 1 && wr[0] && same_addr && a_wr_strobe[k]) rd_word[1][k*8 +: 8] = a_wr_data[k*8 +: 8];
    end
  end
  // Array is not cleared by reset; port A's write is issued last so it wins shared lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= '0;
      v2 <= '0;
      d1 <= '0;
      d2 <= '0;
      collision <= 1'b0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (wr[1] && b_wr_strobe[k]) mem[b_addr][k*8 +: 8] <= b_wr_data[k*8 +: 8];
        if (wr[0] && a_wr_strobe[k]) mem[a_addr][k*8 +: 8] <= a_wr_data[k*8 +: 8];
      end
      v1 <= rd;
      v2 <= v1;
      for (int p = 0; p < 2; p++) begin
        if (rd[p]) d1[p] <= rd_word[p];
        if (v1[p]) d2[p] <= d1[p];
      end
      collision <= &wr && same_addr && |(a_wr_strobe & b_wr_strobe);
    end
  end
  assign a_rd_data  = READ_LATENCY == 2 ? d2[0] : d1[0];
  assign b_rd_data  = READ_LATENCY == 2 ? d2[1] : d1[1];
  assign a_rd_valid = READ_LATENCY == 2 ? v2[0] : v1[0];
  assign b_rd_valid = READ_LATENCY == 2 ? v2[1] : v1[1];
endmodule

// File: tb/tb_ram_dp.sv
// tb_ram_dp: scoreboard bench for ram_dp, latency-1/read-first and latency-2/write-first instances
module tb_ram_dp;
  localparam int AW = 6, DW = 32, NB = 4;
  typedef struct {logic [DW-1:0] d; int c;} exp_t;
  logic clk = 0, rst_n = 0;
  logic a_en, a_we, b_en, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wd, b_wd;
  logic [NB-1:0] a_st, b_st;
  logic [DW-1:0] rdd [4];
  logic rdv [4];
  logic col [2];
  int vectors = 0, miscompares = 0, cyc = 0;
  exp_t sb [4][$];
  int cq [2][$];
  exp_t e;
  int ec;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  ram_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .RDW_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wr_data(a_wd), .a_wr_strobe(a_st),
    .a_rd_data(rdd[0]), .a_rd_valid(rdv[0]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wr_data(b_wd), .b_wr_strobe(b_st),
    .b_rd_data(rdd[1]), .b_rd_valid(rdv[1]), .collision(col[0]));
  ram_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .RDW_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wr_data(a_wd), .a_wr_strobe(a_st),
    .a_rd_data(rdd[2]), .a_rd_valid(rdv[2]),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wr_data(b_wd), .b_wr_strobe(b_st),
    .b_rd_data(rdd[3]), .b_rd_valid(rdv[3]), .collision(col[1]));
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  // Streams: 0 = u0 port A, 1 = u0 port B, 2 = u1 port A, 3 = u1 port B
  always @(negedge clk) begin
    for (int s = 0; s < 4; s++) begin
      if (rdv[s] !== 1'b0) begin
        if (sb[s].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_valid s%0d: got valid=%b data=%h at cycle %0d, expected no valid", s, rdv[s], rdd[s], cyc);
        end else begin
          e = sb[s].pop_front();
          check($sformatf("rd_data s%0d", s), rdd[s], e.d);
          check($sformatf("rd_cycle s%0d", s), 32'(cyc), 32'(e.c));
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (col[i] !== 1'b0) begin
        if (cq[i].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_collision u%0d: got %b at cycle %0d, expected 0", i, col[i], cyc);
        end else begin
          ec = cq[i].pop_front();
          check($sformatf("collision_cycle u%0d", i), 32'(cyc), 32'(ec));
        end
      end
    end
  end
  task automatic idle();
    a_en = 0; a_we = 0; a_addr = '0; a_wd = '0; a_st = '0;
    b_en = 0; b_we = 0; b_addr = '0; b_wd = '0; b_st = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask
  task automatic awr(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [NB-1:0] s);
    a_en = 1; a_we = 1; a_addr = ad; a_wd = d; a_st = s;
  endtask
  task automatic bwr(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [NB-1:0] s);
    b_en = 1; b_we = 1; b_addr = ad; b_wd = d; b_st = s;
  endtask
  task automatic ard(input logic [AW-1:0] ad, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    a_en = 1; a_we = 0; a_addr = ad;
    sb[0].push_back(exp_t'{e0, cyc + 1});
    sb[2].push_back(exp_t'{e1, cyc + 2});
  endtask
  task automatic brd(input logic [AW-1:0] ad, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    b_en = 1; b_we = 0; b_addr = ad;
    sb[1].push_back(exp_t'{e0, cyc + 1});
    sb[3].push_back(exp_t'{e1, cyc + 2});
  endtask
  task automatic expcol();
    cq[0].push_back(cyc + 1);
    cq[1].push_back(cyc + 1);
  endtask
  task automatic check_cleared(input string tag);
    for (int s = 0; s < 4; s++) begin
      check($sformatf("%s rd_data s%0d", tag, s), rdd[s], '0);
      check($sformatf("%s rd_valid s%0d", tag, s), 32'(rdv[s]), 32'd0);
    end
    for (int i = 0; i < 2; i++) check($sformatf("%s collision u%0d", tag, i), 32'(col[i]), 32'd0);
  endtask
  initial begin
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1;
    awr(5, 32'hDEADBEEF, 4'hF); step();
    brd(5, 32'hDEADBEEF, 32'hDEADBEEF); step();
    awr(3, 32'h11223344, 4'hF); step();
    awr(3, 32'hAABBCCDD, 4'b0101); step();
    ard(3, 32'h11BB33DD, 32'h11BB33DD); step();
    awr(7, 32'h0, 4'hF); step();
    awr(7, 32'hFFFFFFFF, 4'h3); brd(7, 32'h00000000, 32'h0000FFFF); step();
    ard(7, 32'h0000FFFF, 32'h0000FFFF); step();
    ard(7, 32'h0000FFFF, 32'h0000FFFF); brd(7, 32'h0000FFFF, 32'h0000FFFF); step();
    awr(9, 32'h0, 4'hF); step();
    awr(9, 32'h11111111, 4'h3); bwr(9, 32'h22222222, 4'h6); expcol(); step();
    ard(9, 32'h00221111, 32'h00221111); step();
    awr(9, 32'h11111111, 4'h3); bwr(9, 32'h22222222, 4'hC); step();
    brd(9, 32'h22221111, 32'h22221111); step();
    awr(9, 32'h33333333, 4'h0); bwr(9, 32'h44444444, 4'hF); step();
    ard(9, 32'h44444444, 32'h44444444); step();
    awr(10, 32'h55555555, 4'hF); bwr(11, 32'h66666666, 4'hF); step();
    ard(10, 32'h55555555, 32'h55555555); brd(11, 32'h66666666, 32'h66666666); step();
    awr(20, 32'h5A5A5A5A, 4'hF); step();
    a_en = 1; a_we = 0; a_addr = 20; step();
    rst_n = 0;
    awr(20, 32'hFFFFFFFF, 4'hF); bwr(21, 32'hFFFFFFFF, 4'hF); step();
    step();
    check_cleared("midreset");
    rst_n = 1;
    repeat (3) step();
    ard(20, 32'h5A5A5A5A, 32'h5A5A5A5A); step();
    for (int i = 0; i < 16; i++) begin
      awr(AW'(i), 32'hC0DE0000 | i, 4'hF); step();
    end
    for (int i = 0; i < 16; i++) begin
      ard(AW'(i), 32'hC0DE0000 | i, 32'hC0DE0000 | i);
      bwr(AW'(16 + i), 32'hB0000000 | i, 4'hF);
      step();
    end
    repeat (4) step();
    check("hold a u0", rdd[0], 32'hC0DE000F);
    check("hold a u1", rdd[2], 32'hC0DE000F);
    for (int i = 0; i < 16; i += 5) begin
      brd(AW'(16 + i), 32'hB0000000 | i, 32'hB0000000 | i); step();
    end
    repeat (4) step();
    for (int s = 0; s < 4; s++) check($sformatf("missing reads s%0d", s), 32'(sb[s].size()), 32'd0);
    for (int i = 0; i < 2; i++) check($sformatf("missing collisions u%0d", i), 32'(cq[i].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
